// File: rtl/hamming_tx_serializer_if.sv
// Word-in / serial-out bundle for hamming_tx_serializer; master is the upstream word source.
`timescale 1ns/1ps
interface hamming_tx_serializer_if;
  logic [3:0] DATA_IN;
  logic       DATA_VALID;
  logic       DATA_READY;
  logic       TX_OUT;
  logic       FRAME_DONE;

  modport master (
    output DATA_IN,
    output DATA_VALID,
    input  DATA_READY,
    input  TX_OUT,
    input  FRAME_DONE
  );

  modport slave (
    input  DATA_IN,
    input  DATA_VALID,
    output DATA_READY,
    output TX_OUT,
    output FRAME_DONE
  );
endinterface

// File: rtl/hamming_tx_serializer.sv
// Hamming(7,4) encoder + serial framer (start, code LSB first, stop); TX_OUT low from the accept edge, word period F+1.
// DATA_READY only in IDLE, valid ignored otherwise; HAMMING_SECDED_EN appends an overall even-parity bit.
`timescale 1ns/1ps
module hamming_tx_serializer #(
  parameter int BIT_CYCLES = 1,
  parameter int STOP_BITS  = 1
) (
  input  logic                    CLK_IN,
  input  logic                    REST,
  hamming_tx_serializer_if.slave  bus
);

`ifdef HAMMING_SECDED_EN
  localparam int CW    = 8;
  localparam int IDX_W = 4;
`else
  localparam int CW    = 7;
  localparam int IDX_W = 3;
`endif

  localparam int CYC_W = $clog2(BIT_CYCLES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(BIT_CYCLES - 1);
  localparam logic [CYC_W-1:0] CYC_ONE   = CYC_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(CW - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  function automatic logic [CW-1:0] encode(input logic [3:0] d);
    logic p1, p2, p4;
    logic [6:0] c;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    c  = {d[3], d[2], d[1], p4, d[0], p2, p1};
`ifdef HAMMING_SECDED_EN
    return {^c, c};
`else
    return c;
`endif
  endfunction

  logic [1:0]       state, nxt_state;
  logic [CYC_W-1:0] cyc, nxt_cyc;
  logic [IDX_W-1:0] idx, nxt_idx;
  logic [CW-1:0]    code, nxt_code;
  logic             tx_q, rdy_q, done_q;
  logic             nxt_tx, nxt_done;
  logic             bit_end;

  assign bit_end = (cyc == CYC_LAST);

  always_comb begin
    nxt_state = state;
    nxt_cyc   = cyc;
    nxt_idx   = idx;
    nxt_code  = code;
    case (state)
      S_IDLE: begin
        if (bus.DATA_VALID) begin
          nxt_state = S_START;
          nxt_code  = encode(bus.DATA_IN);
          nxt_cyc   = '0;
          nxt_idx   = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          nxt_state = S_DATA;
          nxt_cyc   = '0;
          nxt_idx   = '0;
        end else begin
          nxt_cyc = cyc + CYC_ONE;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          nxt_cyc = '0;
          if (idx == DATA_LAST) begin
            nxt_state = S_STOP;
            nxt_idx   = '0;
          end else begin
            nxt_idx = idx + IDX_ONE;
          end
        end else begin
          nxt_cyc = cyc + CYC_ONE;
        end
      end
      default: begin
        // idx is reused to count stop bits
        if (bit_end) begin
          nxt_cyc = '0;
          if (idx == STOP_LAST) begin
            nxt_state = S_IDLE;
            nxt_idx   = '0;
          end else begin
            nxt_idx = idx + IDX_ONE;
          end
        end else begin
          nxt_cyc = cyc + CYC_ONE;
        end
      end
    endcase
  end

  // Outputs are registered decodes of the next state, so they line up with the state they describe.
  always_comb begin
    nxt_tx = 1'b1;
    case (nxt_state)
      S_START: nxt_tx = 1'b0;
      S_DATA:  nxt_tx = nxt_code[nxt_idx[2:0]];
      default: nxt_tx = 1'b1;
    endcase
    nxt_done = (nxt_state == S_STOP) && (nxt_idx == STOP_LAST) && (nxt_cyc == CYC_LAST);
  end

  always_ff @(posedge CLK_IN or posedge REST) begin
    if (REST) begin
      state  <= S_IDLE;
      cyc    <= '0;
      idx    <= '0;
      code   <= '0;
      tx_q   <= 1'b1;
      rdy_q  <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state  <= nxt_state;
      cyc    <= nxt_cyc;
      idx    <= nxt_idx;
      code   <= nxt_code;
      tx_q   <= nxt_tx;
      rdy_q  <= (nxt_state == S_IDLE);
      done_q <= nxt_done;
    end
  end

  assign bus.TX_OUT     = tx_q;
  assign bus.DATA_READY = rdy_q;
  assign bus.FRAME_DONE = done_q;

endmodule

// File: doc/hamming_tx_serializer.md
# hamming_tx_serializer

Hamming(7,4) encoder and serial framer that consumes 4-bit data words and shifts the encoded codeword out on a single line. It sits downstream of the odd-ratio clock divider: its `CLK_IN` is driven by the divider's 50%-duty output, so one `CLK_IN` period is the base serial tick. Each accepted word is sent as a frame: start bit, codeword LSB first, then stop bit(s). A ready/valid handshake lets the upstream word source stall.

## Interface
- `BIT_CYCLES`, default 1: `CLK_IN` cycles each serial bit is held. Legal range is ≥1.
- `STOP_BITS`, default 1: number of stop bits per frame. Legal values are 1 or 2.
- `CLK_IN` (in, 1): the single clock. All state updates on its rising edge.
- `REST` (in, 1): reset, asynchronous, active-high.
- `DATA_IN` (in, 4): data word. `DATA_IN[0]`=d1 … `DATA_IN[3]`=d4.
- `DATA_VALID` (in, 1): upstream has a word on `DATA_IN`.
- `DATA_READY` (out, 1): block can accept a word. High only in IDLE.
- `TX_OUT` (out, 1): serial line. Idles at 1.
- `FRAME_DONE` (out, 1): one-cycle pulse marking the end of a frame.

## Operation
- Encoding:
  - p1=d1^d2^d4, p2=d1^d3^d4, p4=d2^d3^d4.
  - CODE[6:0] = {d4,d3,d2,p4,d1,p2,p1}, i.e. Hamming positions 1..7 mapped to CODE[0..6].
  - CW = 7 bits, or 8 bits with the Configuration macro.
- Handshake:
  - A word is accepted on a rising edge where `DATA_VALID` & `DATA_READY` are both high.
  - `DATA_IN` is sampled and encoded only at acceptance and held internally; later changes have no effect.
  - `DATA_VALID` while `DATA_READY`=0 is ignored. No queuing, no error.
- FSM states: IDLE → START → DATA → STOP → IDLE.
  - IDLE: `TX_OUT`=1, `DATA_READY`=1. Go to START on accept.
  - START: `TX_OUT`=0 for BIT_CYCLES cycles.
  - DATA: `TX_OUT`=CODE[i], for i = 0..CW-1, each held BIT_CYCLES cycles. A bit index counter counts up.
  - STOP: `TX_OUT`=1 for STOP_BITS×BIT_CYCLES cycles. `FRAME_DONE`=1 during the final cycle of the final stop bit. Go to IDLE.
- Counters:
  - Cycle counter width is $clog2(BIT_CYCLES+1). It wraps 0..BIT_CYCLES-1 and clears on every bit transition.
  - Bit index width is 3 bits, or 4 bits with the macro.
- Reset:
  - `REST` high forces IDLE asynchronously.
  - Output values while in reset: `TX_OUT`=1, `DATA_READY`=1, `FRAME_DONE`=0; counters 0, held codeword 0.
  - Reset mid-frame aborts the frame immediately. The partial frame is not resumed and `FRAME_DONE` is not pulsed.
- All outputs are registered. No combinational path from inputs to outputs.

## Timing
- Accept at edge k: `DATA_READY`=0 and `TX_OUT`=0 from edge k.
- First data bit CODE[0] appears at edge k+BIT_CYCLES.
- Frame length F = (1 + CW + STOP_BITS)×BIT_CYCLES cycles.
- `FRAME_DONE` is high in cycle k+F-1. `DATA_READY` returns to 1 at edge k+F.
- Back-to-back words: the earliest next accept is at edge k+F, so the period is F+1 cycles with one idle cycle at `TX_OUT`=1.
- With defaults (CW=7, STOP_BITS=1, BIT_CYCLES=1): F=9 and the word period is 10 cycles.
- With BIT_CYCLES=1 there are no stalls inside a frame. Every bit lasts exactly BIT_CYCLES cycles.

## Configuration
- `HAMMING_SECDED_EN` defined:
  - CW=8 and CODE[7] = ^CODE[6:0] (overall even parity for SEC-DED).
  - It is transmitted after CODE[6]. Default F=10.
- Macro undefined: CW=7. No parity bit is generated or sent.

## Test plan
- Reset, then idle for 5 cycles -> `TX_OUT`=1, `DATA_READY`=1, `FRAME_DONE`=0 throughout.
- Defaults, `DATA_IN`=4'b1011 accepted -> line sequence 0,1,0,1,0,1,0,1,1 (start, CODE=7'h55 LSB first, stop). `FRAME_DONE` in the 9th cycle. `DATA_READY` at the 10th edge. With `HAMMING_SECDED_EN`, a 0 parity bit is inserted before the stop bit.
- Defaults, `DATA_IN`=4'b0001 then 4'b1111 with `DATA_VALID` held high -> CODE=7'h07 then 7'h7F. Accepts are 10 cycles apart. `DATA_IN` changes mid-frame do not alter the line. With the macro, the parity bits are 1 and 1.
- BIT_CYCLES=3, STOP_BITS=2, `DATA_IN`=4'b0000 -> 0 held for 3 cycles, seven 0 bits of 3 cycles each, then 6 cycles of 1. `FRAME_DONE` at cycle 29.
- `DATA_VALID` pulsed during the DATA state -> ignored, no second frame.
- `REST` asserted mid-DATA -> `TX_OUT`=1 and `DATA_READY`=1 asynchronously, no `FRAME_DONE`. The next accept after release sends a complete, correct frame.
